// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the virtual-JTAG debug bridge.
// The IR and DR update strobes arrive asynchronously from the TCK domain.
// Each strobe is synchronised and edge-detected here. An update-IR edge
// latches the instruction register. An update-DR edge captures {ir, data}
// into a small FIFO. The consumer drains that FIFO over valid/ready, and
// each accepted command raises a one-cycle action/no-action pulse on its
// IR channel.
module jtag_debug_cmd_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int DR_WIDTH    = 38,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [DR_WIDTH-1:0]           sr,
    input  logic                          vs_uir,
    input  logic                          vs_udr,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_WIDTH-1:0]           cmd_ir,
    output logic [DR_WIDTH-1:0]           cmd_data,
    output logic [(2**IR_WIDTH)-1:0]      take_action,
    output logic [(2**IR_WIDTH)-1:0]      take_no_action,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int NCH   = 2**IR_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = IR_WIDTH + DR_WIDTH;

    // Synchroniser chains and edge history. Both reset to 1 so that a strobe
    // already high at reset release is not seen as a fresh rising edge.
    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic                   uir_hist_q, uir_hist_d;
    logic                   udr_hist_q, udr_hist_d;

    logic [IR_WIDTH-1:0]    ir_reg_q, ir_reg_d;

    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic [NCH-1:0]         take_action_q, take_action_d;
    logic [NCH-1:0]         take_no_action_q, take_no_action_d;

    logic                   uir_edge, udr_edge;
    logic                   accept, full, wr_en, drop;
    logic [ENT_W-1:0]       head;
    logic [NCH-1:0]         head_onehot;

    // Edge detection, FIFO bookkeeping, overflow and pulse next-state logic
    always_comb begin
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_hist_d = uir_sync_q[SYNC_STAGES-1];
        udr_hist_d = udr_sync_q[SYNC_STAGES-1];
        uir_edge   = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
        udr_edge   = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;

        head      = mem_q[rd_ptr_q];
        cmd_valid = (level_q != '0);
        cmd_ir    = head[ENT_W-1 -: IR_WIDTH];
        cmd_data  = head[DR_WIDTH-1:0];

        accept = cmd_valid & cmd_ready;
        full   = (level_q == LVL_W'(FIFO_DEPTH));
        // A full FIFO still takes a write when the head leaves in the same cycle.
        wr_en  = udr_edge & (~full | accept);
        drop   = udr_edge & full & ~accept;

        // A coincident IR update lands after this capture, so the capture
        // sees the previous IR.
        ir_reg_d = uir_edge ? ir_in : ir_reg_q;

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {ir_reg_q, sr};
        end
        wr_ptr_d = wr_en  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = accept ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        if (wr_en && !accept) begin
            level_d = level_q + LVL_W'(1);
        end else if (!wr_en && accept) begin
            level_d = level_q - LVL_W'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        head_onehot          = '0;
        head_onehot[cmd_ir]  = 1'b1;
        take_action_d        = '0;
        take_no_action_d     = '0;
        if (accept) begin
            if (head[DR_WIDTH-1]) begin
                take_action_d = head_onehot;
            end else begin
                take_no_action_d = head_onehot;
            end
        end
    end

    // Control state: synchronisers, IR, pointers, level, overflow, pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync_q       <= '1;
            udr_sync_q       <= '1;
            uir_hist_q       <= 1'b1;
            udr_hist_q       <= 1'b1;
            ir_reg_q         <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            overflow_q       <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
        end else begin
            uir_sync_q       <= uir_sync_d;
            udr_sync_q       <= udr_sync_d;
            uir_hist_q       <= uir_hist_d;
            udr_hist_q       <= udr_hist_d;
            ir_reg_q         <= ir_reg_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            overflow_q       <= overflow_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
        end
    end

    // Command storage: contents are meaningful only below the level count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign fifo_level     = level_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_jtag_debug_cmd_bridge.sv
// Bench for jtag_debug_cmd_bridge. It runs directed scenarios and then a
// randomized run. A queue-based reference model is compared after every
// clock edge.
module tb_jtag_debug_cmd_bridge;

    localparam int IRW   = 2;
    localparam int DRW   = 38;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int NCH   = 1 << IRW;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [IRW-1:0]  ir_in = '0;
    logic [DRW-1:0]  sr = '0;
    logic            vs_uir = 1'b0;
    logic            vs_udr = 1'b0;
    logic            cmd_valid;
    logic            cmd_ready = 1'b0;
    logic [IRW-1:0]  cmd_ir;
    logic [DRW-1:0]  cmd_data;
    logic [NCH-1:0]  take_action;
    logic [NCH-1:0]  take_no_action;
    logic [LW-1:0]   fifo_level;
    logic            overflow;
    logic            clear_overflow = 1'b0;

    always #5 clk = ~clk;

    jtag_debug_cmd_bridge #(
        .IR_WIDTH(IRW), .DR_WIDTH(DRW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
        .vs_uir(vs_uir), .vs_udr(vs_udr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .take_action(take_action), .take_no_action(take_no_action),
        .fifo_level(fifo_level), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a rising strobe seen at edge r takes effect at edge r+SYNC.
    logic [IRW+DRW-1:0] m_q[$];
    int                 udr_due[$];
    int                 uir_due[$];
    logic [IRW-1:0]     m_ir = '0;
    logic               m_ovf = 1'b0;
    logic [NCH-1:0]     m_act = '0;
    logic [NCH-1:0]     m_nact = '0;
    logic               udr_prev = 1'b1;
    logic               uir_prev = 1'b1;
    int                 cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic               acc, cap, upd, drop;
        logic [IRW+DRW-1:0] hd;
        cyc++;
        if (reset) begin
            m_q.delete();
            udr_due.delete();
            uir_due.delete();
            m_ir = '0; m_ovf = 1'b0; m_act = '0; m_nact = '0;
            udr_prev = 1'b1; uir_prev = 1'b1;
        end else begin
            acc = (m_q.size() != 0) && cmd_ready;
            m_act = '0; m_nact = '0;
            if (acc) begin
                hd = m_q[0];
                if (hd[DRW-1]) m_act[hd[IRW+DRW-1 -: IRW]] = 1'b1;
                else           m_nact[hd[IRW+DRW-1 -: IRW]] = 1'b1;
                void'(m_q.pop_front());
            end
            cap = (udr_due.size() != 0) && (udr_due[0] == cyc);
            upd = (uir_due.size() != 0) && (uir_due[0] == cyc);
            if (cap) void'(udr_due.pop_front());
            if (upd) void'(uir_due.pop_front());
            drop = 1'b0;
            if (cap) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_ir, sr});
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            if (upd) m_ir = ir_in;
            if (vs_udr && !udr_prev) udr_due.push_back(cyc + SYNC);
            if (vs_uir && !uir_prev) uir_due.push_back(cyc + SYNC);
            udr_prev = vs_udr;
            uir_prev = vs_uir;
        end
    endtask

    task automatic compare();
        logic [IRW+DRW-1:0] hd;
        check("cmd_valid", 64'(cmd_valid), 64'(m_q.size() != 0));
        check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("take_action", 64'(take_action), 64'(m_act));
        check("take_no_action", 64'(take_no_action), 64'(m_nact));
        if (m_q.size() != 0) begin
            hd = m_q[0];
            check("cmd_ir", 64'(cmd_ir), 64'(hd[IRW+DRW-1 -: IRW]));
            check("cmd_data", 64'(cmd_data), 64'(hd[DRW-1:0]));
        end
    endtask

    // One clock: inputs set before the edge, outputs checked on the falling edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare();
        end
    endtask

    task automatic pulse_udr(input logic [DRW-1:0] val);
        sr = val;
        vs_udr = 1'b1;
        step(2);
        vs_udr = 1'b0;
        step(2);
    endtask

    task automatic pulse_uir(input logic [IRW-1:0] val);
        ir_in = val;
        vs_uir = 1'b1;
        step(2);
        vs_uir = 1'b0;
        step(2);
    endtask

    initial begin
        logic [63:0] rnd;
        @(negedge clk);
        // Reset state
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);
        check("reset_valid", 64'(cmd_valid), 64'(0));
        check("reset_level", 64'(fifo_level), 64'(0));
        check("reset_ovf", 64'(overflow), 64'(0));
        check("reset_pulse", 64'({take_action, take_no_action}), 64'(0));

        // Single command with latency check
        pulse_uir(2'b01);
        sr = 38'h20_0000_00AB;
        cmd_ready = 1'b1;
        vs_udr = 1'b1;
        step();
        check("lat_e0", 64'(cmd_valid), 64'(0));
        step();
        check("lat_e1", 64'(cmd_valid), 64'(0));
        step();
        check("lat_e2", 64'(cmd_valid), 64'(1));
        check("single_ir", 64'(cmd_ir), 64'(1));
        check("single_data", 64'(cmd_data), 64'(38'h20_0000_00AB));
        vs_udr = 1'b0;
        step();
        check("single_act", 64'(take_action), 64'(4'b0010));
        check("single_empty", 64'(cmd_valid), 64'(0));
        step();
        check("single_act_end", 64'(take_action), 64'(0));

        // Fill past capacity, then drain in order
        cmd_ready = 1'b0;
        pulse_uir(2'b00);
        for (int i = 1; i <= 5; i++) pulse_udr(DRW'(i));
        check("fill_level", 64'(fifo_level), 64'(4));
        check("fill_ovf", 64'(overflow), 64'(1));
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 64'(cmd_data), 64'(i));
            step();
            check("drain_nact", 64'(take_no_action), 64'(4'b0001));
        end
        cmd_ready = 1'b0;
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'(0));

        // Full FIFO with a write and an accept on the same edge
        for (int i = 10; i <= 13; i++) pulse_udr(DRW'(i));
        sr = DRW'(14);
        vs_udr = 1'b1;
        step(2);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        check("rw_level", 64'(fifo_level), 64'(4));
        check("rw_ovf", 64'(overflow), 64'(0));
        cmd_ready = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            check("rw_order", 64'(cmd_data), 64'(i));
            step();
        end
        cmd_ready = 1'b0;
        step();

        // Coincident IR and DR updates
        ir_in = 2'd3;
        sr = DRW'(38'h1234);
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        step(3);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        step(2);
        check("coinc_old_ir", 64'(cmd_ir), 64'(0));
        pulse_udr(DRW'(38'h5678));
        check("coinc_level", 64'(fifo_level), 64'(2));
        cmd_ready = 1'b1;
        step();
        check("coinc_new_ir", 64'(cmd_ir), 64'(3));
        step(2);
        cmd_ready = 1'b0;

        // Reset released with update-DR still high
        sr = DRW'(38'h77);
        vs_udr = 1'b1;
        step(3);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(4);
        check("rst_hold_level", 64'(fifo_level), 64'(0));
        vs_udr = 1'b0;
        step(2);
        vs_udr = 1'b1;
        step(3);
        check("rst_rearm_level", 64'(fifo_level), 64'(1));
        vs_udr = 1'b0;
        step(2);
        cmd_ready = 1'b1;
        step(2);
        cmd_ready = 1'b0;

        // Set beats clear on the same edge
        for (int i = 20; i <= 23; i++) pulse_udr(DRW'(i));
        sr = DRW'(24);
        vs_udr = 1'b1;
        step(2);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        vs_udr = 1'b0;
        check("ovf_prio", 64'(overflow), 64'(1));
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("ovf_clear", 64'(overflow), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(5) == 0) vs_uir = ~vs_uir;
            cmd_ready      = ($urandom_range(2) != 0);
            clear_overflow = ($urandom_range(15) == 0);
            ir_in          = IRW'($urandom);
            rnd            = {$urandom, $urandom};
            sr             = rnd[DRW-1:0];
            reset          = ($urandom_range(149) == 0);
            step();
        end
        reset = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_debug_cmd_bridge.md
Name: jtag_debug_cmd_bridge

Overview:
- System-clock-side successor to the debug module's sysclk decoder. Synchronises the virtual-JTAG update strobes and latches the instruction register (IR). Captures each completed data-register (DR) scan as an {ir, data} command into a parametrised FIFO.
- Delivers commands over a valid/ready interface, with per-IR-code action/no-action pulses on acceptance.
- Sits between the TCK-domain shift logic and the debug-core consumers: OCI memory, break unit and trace control.

Parameters:
- IR_WIDTH, 2, instruction-register width; 2**IR_WIDTH decoded channels.
- DR_WIDTH, 38, captured shift-register width; MSB is the action bit.
- FIFO_DEPTH, 4, command buffer entries; power of 2, >= 2.
- SYNC_STAGES, 2, synchroniser flops per strobe; >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
- ir_in  in  IR_WIDTH  IR value from TCK domain; quasi-static around vs_uir.
- sr  in  DR_WIDTH  shift-register contents; quasi-static after vs_udr rises.
- vs_uir  in  1  virtual update-IR strobe; asynchronous level.
- vs_udr  in  1  virtual update-DR strobe; asynchronous level.
- cmd_valid  out  1  FIFO non-empty.
- cmd_ready  in  1  consumer accepts the head entry.
- cmd_ir  out  IR_WIDTH  head-entry IR.
- cmd_data  out  DR_WIDTH  head-entry data (jdo equivalent).
- take_action  out  2**IR_WIDTH  one-hot pulse: accepted command with action bit = 1.
- take_no_action  out  2**IR_WIDTH  one-hot pulse: accepted command with action bit = 0.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  sticky: a capture was dropped.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset values:
  - sync chains and edge-history flops = 1. Suppresses a spurious edge if a strobe is high at release.
  - ir_reg = 0; pointers = 0; fifo_level = 0; cmd_valid = 0; overflow = 0; take_action/take_no_action = 0.
  - cmd_ir/cmd_data = whatever entry 0 holds (don't-care while cmd_valid = 0).
- Synchroniser: each strobe passes through SYNC_STAGES flops. Edge = last stage & ~history flop (history = last stage delayed one clk).
- uir edge: ir_reg <= ir_in.
- udr edge: write {ir_reg, sr} at wr_ptr.
  - If uir and udr edges coincide, the capture uses ir_reg before update.
- Latency: strobe rise sampled at clk edge 0 -> edge flag true in cycle SYNC_STAGES -> write on that cycle's edge -> cmd_valid = 1 in cycle SYNC_STAGES+1.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is maintained explicitly.
  - cmd_valid = (fifo_level != 0). Head is read combinationally from the register array.
  - Accept = cmd_valid & cmd_ready. Pops the head; rd_ptr advances.
- Write when not full: accepted.
- Write when full: accepted only if an accept occurs the same cycle (level unchanged). Otherwise dropped and overflow <= 1.
- Accept on empty: impossible (cmd_valid = 0); cmd_ready is ignored.
- Backpressure: while cmd_valid & ~cmd_ready, cmd_ir/cmd_data are held stable.
- overflow:
  - Set has priority over clear_overflow in the same cycle.
  - Otherwise clear_overflow sets overflow <= 0.
- Pulses: registered. On the cycle after an accept, bit cmd_ir of take_action (data MSB = 1) or take_no_action (MSB = 0) is high for exactly 1 cycle; all other bits are 0.
  - Back-to-back accepts give back-to-back pulses.
- Reset mid-operation: FIFO contents discarded; any pulse in flight is cancelled.
  - A strobe still high after release produces no capture until it falls and rises again.

Test Plan:
- Single command: reset released, ir_in=2'b01, pulse vs_uir; sr=38'h20_0000_00AB, pulse vs_udr; cmd_ready=1 -> cmd_valid high 3 cycles after vs_udr sampled (SYNC_STAGES=2), cmd_ir=1, cmd_data=38'h20_0000_00AB, take_action=4'b0010 for 1 cycle next cycle.
- Fill/overflow: cmd_ready=0, 5 udr pulses with sr=1..5 -> fifo_level=4, overflow=1; then drain -> data 1,2,3,4 in order, take_no_action=4'b0001 each.
- Full with simultaneous read/write: level=4, udr edge coincides with accept -> level stays 4, overflow stays 0, new entry emerges last.
- Coincident uir/udr edges: ir_reg=0, ir_in=3, both strobes rise same clk -> captured cmd_ir=0; next capture cmd_ir=3.
- Reset with vs_udr held high: assert reset 3 cycles, release with vs_udr=1 -> no capture, level=0; lower then raise vs_udr -> exactly one entry.
- Overflow clear priority: drop event and clear_overflow in same cycle -> overflow=1; clear alone next cycle -> overflow=0.
